// File: rtl/axi_bram_writer_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) for axi_bram_writer.
interface axi_bram_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_bram_writer.sv
// AXI4-Lite write-only slave feeding BRAM port A, one word per transaction.
// Define AXI_BRAM_WRITER_WSTRB_EN to honour wstrb as byte write enables.
module axi_bram_writer #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    axi_bram_writer_if.slave             s_axi,
    output logic                         bram_porta_clk,
    output logic                         bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
    output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we
);
    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int WE_W     = BRAM_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int ADDR_MSB = ADDR_LSB + BRAM_ADDR_WIDTH - 1;

    logic                       aw_full;
    logic                       w_full;
    logic                       bvalid;
    logic                       aw_hs;
    logic                       w_hs;
    logic                       wr_fire;
    logic [BRAM_ADDR_WIDTH-1:0] aw_addr_q;
    logic [BRAM_DATA_WIDTH-1:0] w_data_q;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q;
    logic [BRAM_DATA_WIDTH-1:0] wrdata_q;

    // Upper awaddr bits are dropped on purpose: addresses wrap over the BRAM.
    logic [AXI_ADDR_WIDTH-1:0]  unused_awaddr;
    assign unused_awaddr = s_axi.awaddr;

    assign aw_hs   = s_axi.awvalid & ~aw_full;
    assign w_hs    = s_axi.wvalid & ~w_full;
    assign wr_fire = aw_full & w_full & ~bvalid;

    assign s_axi.awready = ~aw_full;
    assign s_axi.wready  = ~w_full;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bvalid  = bvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
        end else if (wr_fire) begin
            aw_full   <= 1'b0;
        end else if (aw_hs) begin
            aw_full   <= 1'b1;
            aw_addr_q <= s_axi.awaddr[ADDR_MSB:ADDR_LSB];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_full   <= 1'b0;
            w_data_q <= '0;
        end else if (wr_fire) begin
            w_full   <= 1'b0;
        end else if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= s_axi.wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid <= 1'b0;
        end else if (wr_fire) begin
            bvalid <= 1'b1;
        end else if (bvalid && s_axi.bready) begin
            bvalid <= 1'b0;
        end
    end

    // Port A address/data keep the last written word between write cycles.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q   <= '0;
            wrdata_q <= '0;
        end else if (wr_fire) begin
            addr_q   <= aw_addr_q;
            wrdata_q <= w_data_q;
        end
    end

    assign bram_porta_clk    = aclk;
    assign bram_porta_rst    = ~aresetn;
    assign bram_porta_addr   = wr_fire ? aw_addr_q : addr_q;
    assign bram_porta_wrdata = wr_fire ? w_data_q : wrdata_q;

`ifdef AXI_BRAM_WRITER_WSTRB_EN
    logic [WE_W-1:0] w_strb_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_strb_q <= '0;
        end else if (w_hs) begin
            w_strb_q <= s_axi.wstrb;
        end
    end

    assign bram_porta_we = wr_fire ? w_strb_q : '0;
`else
    logic [STRB_W-1:0] unused_wstrb;
    assign unused_wstrb  = s_axi.wstrb;
    assign bram_porta_we = {WE_W{wr_fire}};
`endif
endmodule

// File: tb/tb_axi_bram_writer.sv
// Randomized self-checking bench for axi_bram_writer with a queue-based model.
module tb_axi_bram_writer;
    logic aclk = 1'b0;
    logic aresetn = 1'b1;

    axi_bram_writer_if #(.ADDR_W(16), .DATA_W(32)) axi ();

    logic        bram_clk;
    logic        bram_rst;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wrdata;
    logic [3:0]  bram_we;

    int nerr = 0;
    int ncheck = 0;
    bit chk_on = 1'b0;

    axi_bram_writer #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(16),
        .BRAM_DATA_WIDTH(32),
        .BRAM_ADDR_WIDTH(10)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axi(axi),
        .bram_porta_clk(bram_clk),
        .bram_porta_rst(bram_rst),
        .bram_porta_addr(bram_addr),
        .bram_porta_wrdata(bram_wrdata),
        .bram_porta_we(bram_we)
    );

    always #5 aclk = ~aclk;

    // Model: accepted-but-unwritten transactions, pending B, last port A word.
    logic [9:0]  awq[$];
    logic [31:0] wdq[$];
    logic [3:0]  wsq[$];
    logic        m_bvalid = 1'b0;
    logic [9:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] mem_model [1024];
    logic [31:0] dut_mem [1024];

    localparam logic [3:0] EXP_0101 =
`ifdef AXI_BRAM_WRITER_WSTRB_EN
        4'b0101;
`else
        4'hF;
`endif

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic m_fire();
        return awq.size() != 0 && wdq.size() != 0 && !m_bvalid;
    endfunction

    function automatic logic [3:0] m_we();
        if (!m_fire()) return 4'h0;
`ifdef AXI_BRAM_WRITER_WSTRB_EN
        return wsq[0];
`else
        return 4'hF;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    bit fire, ahs, whs;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awq.delete();
            wdq.delete();
            wsq.delete();
            m_bvalid <= 1'b0;
            m_addr   <= '0;
            m_data   <= '0;
        end else begin
            fire = m_fire();
            ahs  = axi.awvalid && awq.size() == 0;
            whs  = axi.wvalid && wdq.size() == 0;
            if (fire) begin
                mem_model[awq[0]] <= merge(mem_model[awq[0]], wdq[0], m_we());
                m_addr   <= awq[0];
                m_data   <= wdq[0];
                m_bvalid <= 1'b1;
                void'(awq.pop_front());
                void'(wdq.pop_front());
                void'(wsq.pop_front());
            end else if (m_bvalid && axi.bready) begin
                m_bvalid <= 1'b0;
            end
            if (ahs) awq.push_back(axi.awaddr[11:2]);
            if (whs) begin
                wdq.push_back(axi.wdata);
                wsq.push_back(axi.wstrb);
            end
        end
    end

    always @(negedge aclk) begin
        if (chk_on) begin
            chk("awready", axi.awready, awq.size() == 0);
            chk("wready", axi.wready, wdq.size() == 0);
            chk("bvalid", axi.bvalid, m_bvalid);
            chk("bresp", axi.bresp, 2'b00);
            chk("we", bram_we, m_we());
            chk("addr", bram_addr, m_fire() ? awq[0] : m_addr);
            chk("wrdata", bram_wrdata, m_fire() ? wdq[0] : m_data);
            chk("porta_rst", bram_rst, !aresetn);
            chk("porta_clk", bram_clk, aclk);
            if (bram_we != 4'h0)
                dut_mem[bram_addr] <= merge(dut_mem[bram_addr], bram_wrdata, bram_we);
        end
    end

    task automatic neg();
        @(negedge aclk);
    endtask

    task automatic idle();
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
    endtask

    task automatic put_aw(input logic [15:0] a);
        axi.awvalid = 1'b1;
        axi.awaddr  = a;
    endtask

    task automatic put_w(input logic [31:0] d, input logic [3:0] s);
        axi.wvalid = 1'b1;
        axi.wdata  = d;
        axi.wstrb  = s;
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 1024; i++) begin
            mem_model[i] = '0;
            dut_mem[i]   = '0;
        end
        axi.awaddr = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        #3 aresetn = 1'b0;
        repeat (2) neg();
        #1 aresetn = 1'b1;
        chk_on = 1'b1;
        neg();
        chk("rst_awready", axi.awready, 1'b1);
        chk("rst_wready", axi.wready, 1'b1);
        chk("rst_bvalid", axi.bvalid, 1'b0);
        chk("rst_we", bram_we, 4'h0);
        chk("rst_addr", bram_addr, 10'd0);
        chk("rst_wrdata", bram_wrdata, 32'd0);

        // Same-cycle AW/W
        #1 put_aw(16'h0010); put_w(32'hDEADBEEF, 4'hF);
        neg();
        chk("a_we", bram_we, 4'hF);
        chk("a_addr", bram_addr, 10'd4);
        chk("a_data", bram_wrdata, 32'hDEADBEEF);
        chk("a_model_addr", awq[0], 10'd4);
        #1 idle();
        neg();
        chk("a_we_off", bram_we, 4'h0);
        chk("a_bvalid", axi.bvalid, 1'b1);
        chk("a_bresp", axi.bresp, 2'b00);
        neg();
        chk("a_bdone", axi.bvalid, 1'b0);

        // W first, AW three cycles later
        #1 put_w(32'h12345678, 4'hF);
        neg();
        chk("b_wready", axi.wready, 1'b0);
        chk("b_no_we", bram_we, 4'h0);
        #1 idle();
        repeat (2) neg();
        #1 put_aw(16'h0008);
        neg();
        chk("b_we", bram_we, 4'hF);
        chk("b_addr", bram_addr, 10'd2);
        chk("b_data", bram_wrdata, 32'h12345678);
        #1 idle();
        neg();
        chk("b_bvalid", axi.bvalid, 1'b1);

        // B back-pressure with a second pair waiting
        neg();
        #1 axi.bready = 1'b0; put_aw(16'h0020); put_w(32'h1, 4'hF);
        neg();
        chk("c_we1", bram_we, 4'hF);
        chk("c_addr1", bram_addr, 10'd8);
        #1 idle();
        neg();
        chk("c_bvalid", axi.bvalid, 1'b1);
        #1 put_aw(16'h0024); put_w(32'h2, 4'hF);
        neg();
        chk("c_awready", axi.awready, 1'b0);
        chk("c_wready", axi.wready, 1'b0);
        chk("c_blocked", bram_we, 4'h0);
        #1 idle();
        repeat (3) begin
            neg();
            chk("c_hold_we", bram_we, 4'h0);
            chk("c_hold_b", axi.bvalid, 1'b1);
        end
        #1 axi.bready = 1'b1;
        neg();
        chk("c_we2", bram_we, 4'hF);
        chk("c_addr2", bram_addr, 10'd9);
        chk("c_data2", bram_wrdata, 32'h2);
        chk("c_b_cleared", axi.bvalid, 1'b0);
        neg();
        chk("c_bvalid2", axi.bvalid, 1'b1);
        neg();

        // Address wrap beyond 1K words
        #1 put_aw(16'h1004); put_w(32'hCAFEF00D, 4'hF);
        neg();
        chk("d_addr_wrap", bram_addr, 10'd1);
        chk("d_we", bram_we, 4'hF);
        #1 idle();
        repeat (2) neg();

        // Partial strobes
        #1 put_aw(16'h0040); put_w(32'hA5A5A5A5, 4'b0101);
        neg();
        chk("e_we", bram_we, EXP_0101);
        chk("e_model_we", m_we(), EXP_0101);
        #1 idle();
        repeat (2) neg();

        // Reset while AW held and B pending
        #1 axi.bready = 1'b0; put_aw(16'h0030); put_w(32'h3, 4'hF);
        neg();
        #1 idle();
        neg();
        chk("f_bvalid", axi.bvalid, 1'b1);
        #1 put_aw(16'h0034);
        neg();
        chk("f_aw_full", axi.awready, 1'b0);
        #1 idle();
        #1 aresetn = 1'b0;
        #1;
        chk("f_rst_bvalid", axi.bvalid, 1'b0);
        chk("f_rst_we", bram_we, 4'h0);
        neg();
        #1 aresetn = 1'b1; axi.bready = 1'b1;
        neg();
        chk("f_awready", axi.awready, 1'b1);
        chk("f_no_write", bram_we, 4'h0);
        chk("f_no_b", axi.bvalid, 1'b0);
        repeat (2) neg();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            #1;
            axi.awvalid = ($urandom_range(0, 2) != 0);
            axi.awaddr  = 16'($urandom);
            axi.wvalid  = ($urandom_range(0, 2) != 0);
            axi.wdata   = $urandom;
            axi.wstrb   = 4'($urandom_range(0, 15));
            axi.bready  = ($urandom_range(0, 3) != 0);
            neg();
        end
        #1 idle(); axi.bready = 1'b1;
        repeat (6) neg();

        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (dut_mem[i] !== mem_model[i]) bad++;
        chk("mem_image", bad, 0);

        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end
endmodule
